fp16_accumulator: RTL and testbench

//  Downstream stage of the fp16 MAC: consumes the registered fp16 products of the multiplier and

---
 rtl/fp16_pkg.sv | 54 +++++
 rtl/fp16_accumulator_if.sv | 34 +++
 rtl/fp16_norm.sv | 52 +++++
 rtl/fp16_accumulator.sv | 198 +++++++++++++++++++
 tb/tb_fp16_accumulator.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/fp16_pkg.sv
//------------------------------------------------------------------------------
// Module   : fp16_pkg
// Brief    : Shared fp16 field widths, special encodings, FSM states and helpers.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package fp16_pkg;

  localparam int EXP_W   = 5;
  localparam int MAN_W   = 10;
  localparam int FP_W    = 1 + EXP_W + MAN_W;
  localparam int BIAS    = 15;
  localparam int EXP_MAX = 31;

  localparam logic [FP_W-1:0] POS_ZERO = 16'h0000;
  localparam logic [FP_W-1:0] POS_INF  = 16'h7C00;
  localparam logic [FP_W-1:0] QNAN     = 16'h7E00;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ALIGN = 2'd1,
    ADD   = 2'd2,
    NORM  = 2'd3
  } state_t;

  function automatic logic fp_sign(input logic [FP_W-1:0] x);
    return x[FP_W-1];
  endfunction

  function automatic logic [EXP_W-1:0] fp_exp(input logic [FP_W-1:0] x);
    return x[FP_W-2:MAN_W];
  endfunction

  function automatic logic [MAN_W-1:0] fp_man(input logic [FP_W-1:0] x);
    return x[MAN_W-1:0];
  endfunction

  // Subnormals are deliberately folded into zero.
  function automatic logic is_zero(input logic [FP_W-1:0] x);
    return fp_exp(x) == '0;
  endfunction

  function automatic logic is_inf(input logic [FP_W-1:0] x);
    return (fp_exp(x) == '1) && (fp_man(x) == '0);
  endfunction

  function automatic logic is_nan(input logic [FP_W-1:0] x);
    return (fp_exp(x) == '1) && (fp_man(x) != '0);
  endfunction

endpackage

`default_nettype wire

// File: rtl/fp16_accumulator_if.sv
//------------------------------------------------------------------------------
// Module   : fp16_accumulator_if
// Brief    : Product-in / result-out handshake bundle of the fp16 accumulator.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface fp16_accumulator_if
  import fp16_pkg::*;
#(
  parameter int CNT_W = 16
);

  logic             in_valid;
  logic             in_ready;
  logic [FP_W-1:0]  in_data;
  logic             in_last;
  logic             out_valid;
  logic [FP_W-1:0]  out_data;
  logic [CNT_W-1:0] out_count;

  modport master (
    output in_valid, in_data, in_last,
    input  in_ready, out_valid, out_data, out_count
  );

  modport slave (
    input  in_valid, in_data, in_last,
    output in_ready, out_valid, out_data, out_count
  );

endinterface

`default_nettype wire

// File: rtl/fp16_norm.sv
//------------------------------------------------------------------------------
// Module   : fp16_norm
// Brief    : Combinational carry/leading-zero normalisation of the raw sum.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module fp16_norm
  import fp16_pkg::*;
#(
  parameter int SIG_W = 14,
  parameter int E_W   = 5
) (
  input  logic [SIG_W:0]   i_sum,
  input  logic [E_W-1:0]   i_exp,
  output logic [SIG_W-1:0] o_sig,
  output logic [E_W+1:0]   o_exp,
  output logic             o_zero
);

  localparam int LZ_W = $clog2(SIG_W + 1);
  localparam int XW   = E_W + 2;

  logic [LZ_W-1:0] w_lzc;
  logic            w_found;

  always_comb begin
    w_lzc   = '0;
    w_found = 1'b0;
    for (int i = SIG_W - 1; i >= 0; i--) begin
      if (!w_found && i_sum[i]) begin
        w_lzc   = LZ_W'(SIG_W - 1 - i);
        w_found = 1'b1;
      end
    end
  end

  // Exponent is two bits wider so underflow shows up as a negative value.
  always_comb begin
    o_zero = (i_sum == '0);
    if (i_sum[SIG_W]) begin
      o_sig = {i_sum[SIG_W:2], i_sum[1] | i_sum[0]};
      o_exp = {2'b00, i_exp} + XW'(1);
    end else begin
      o_sig = i_sum[SIG_W-1:0] << w_lzc;
      o_exp = {2'b00, i_exp} - XW'(w_lzc);
    end
  end

endmodule

`default_nettype wire

// File: rtl/fp16_accumulator.sv
//------------------------------------------------------------------------------
// Module   : fp16_accumulator
// Brief    : Multi-cycle fp16 running-sum accumulator closing on in_last.
//            Define FP16_ACC_RNE_EN for round-to-nearest-even (else truncate).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module fp16_accumulator
  import fp16_pkg::*;
#(
  parameter int EXP_W = fp16_pkg::EXP_W,
  parameter int MAN_W = fp16_pkg::MAN_W,
  parameter int CNT_W = 16
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              clear,
  output logic              busy,
  fp16_accumulator_if.slave bus
);

  localparam int SIG_W = MAN_W + 1;
  localparam int EXT_W = SIG_W + 3;
  localparam int XW    = EXP_W + 2;

  state_t           r_state;
  logic [FP_W-1:0]  r_acc, r_opb, r_spec_val, r_out_data;
  logic [CNT_W-1:0] r_count, r_out_count;
  logic             r_last, r_sign, r_sub, r_spec, r_out_valid;
  logic [EXP_W-1:0] r_exp;
  logic [EXT_W-1:0] r_a_ext, r_b_ext;
  logic [EXT_W:0]   r_sum;

  function automatic logic [EXT_W-1:0] ext_sig(input logic [FP_W-1:0] x);
    return is_zero(x) ? '0 : {1'b1, fp_man(x), 3'b000};
  endfunction

  // Alignment: the larger magnitude becomes A, B is shifted with sticky.
  logic             w_swap;
  logic [FP_W-1:0]  w_big, w_small, w_spec_val;
  logic [EXT_W-1:0] w_small_ext, w_small_sh;
  logic [EXP_W-1:0] w_diff;

  assign w_swap      = r_opb[FP_W-2:0] > r_acc[FP_W-2:0];
  assign w_big       = w_swap ? r_opb : r_acc;
  assign w_small     = w_swap ? r_acc : r_opb;
  assign w_small_ext = ext_sig(w_small);
  assign w_diff      = fp_exp(w_big) - fp_exp(w_small);

  always_comb begin
    w_small_sh = '0;
    if (w_diff >= EXP_W'(EXT_W)) begin
      w_small_sh[0] = |w_small_ext;
    end else begin
      w_small_sh    = w_small_ext >> w_diff;
      w_small_sh[0] = w_small_sh[0] | (|(w_small_ext & ~({EXT_W{1'b1}} << w_diff)));
    end
  end

  always_comb begin
    if (is_nan(r_acc) || is_nan(r_opb))
      w_spec_val = QNAN;
    else if (is_inf(r_acc) && is_inf(r_opb))
      w_spec_val = (fp_sign(r_acc) == fp_sign(r_opb)) ? r_acc : QNAN;
    else if (is_inf(r_acc))
      w_spec_val = r_acc;
    else
      w_spec_val = r_opb;
  end

  logic [EXT_W-1:0] w_norm_sig;
  logic [XW-1:0]    w_norm_exp, w_fin_exp;
  logic             w_norm_zero;
  logic [MAN_W-1:0] w_fin_man;
  logic [FP_W-1:0]  w_result;
  logic [CNT_W-1:0] w_cnt_inc;

  fp16_norm #(
    .SIG_W (EXT_W),
    .E_W   (EXP_W)
  ) u_norm (
    .i_sum  (r_sum),
    .i_exp  (r_exp),
    .o_sig  (w_norm_sig),
    .o_exp  (w_norm_exp),
    .o_zero (w_norm_zero)
  );

`ifdef FP16_ACC_RNE_EN
  logic           w_rnd_up;
  logic [SIG_W:0] w_rnd;

  always_comb begin
    w_rnd_up  = w_norm_sig[2] & (w_norm_sig[1] | w_norm_sig[0] | w_norm_sig[3]);
    w_rnd     = {1'b0, w_norm_sig[EXT_W-1:3]} + (SIG_W + 1)'(w_rnd_up);
    w_fin_exp = w_norm_exp;
    w_fin_man = w_rnd[MAN_W-1:0];
    if (w_rnd[SIG_W]) begin
      w_fin_exp = w_norm_exp + XW'(1);
      w_fin_man = w_rnd[MAN_W:1];
    end
  end
`else
  logic w_unused_grs;

  assign w_unused_grs = ^{w_norm_sig[EXT_W-1], w_norm_sig[2:0]};
  assign w_fin_exp    = w_norm_exp;
  assign w_fin_man    = w_norm_sig[EXT_W-2:3];
`endif

  always_comb begin
    if (r_spec)
      w_result = r_spec_val;
    else if (w_norm_zero || w_fin_exp[XW-1] || (w_fin_exp == '0))
      w_result = POS_ZERO;
    else if (w_fin_exp >= XW'(EXP_MAX))
      w_result = {r_sign, POS_INF[FP_W-2:0]};
    else
      w_result = {r_sign, w_fin_exp[EXP_W-1:0], w_fin_man};
  end

  assign w_cnt_inc     = (r_count == '1) ? r_count : r_count + CNT_W'(1);
  assign bus.in_ready  = (r_state == IDLE) && !clear;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.out_count = r_out_count;
  assign busy          = (r_state != IDLE);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state     <= IDLE;
      r_acc       <= POS_ZERO;
      r_count     <= '0;
      r_opb       <= '0;
      r_last      <= 1'b0;
      r_sign      <= 1'b0;
      r_sub       <= 1'b0;
      r_exp       <= '0;
      r_a_ext     <= '0;
      r_b_ext     <= '0;
      r_sum       <= '0;
      r_spec      <= 1'b0;
      r_spec_val  <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_count <= '0;
    end else if (clear) begin
      r_state     <= IDLE;
      r_acc       <= POS_ZERO;
      r_count     <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.in_valid) begin
            r_opb   <= bus.in_data;
            r_last  <= bus.in_last;
            r_state <= ALIGN;
          end
        end
        ALIGN: begin
          r_sign     <= fp_sign(w_big);
          r_sub      <= fp_sign(w_big) ^ fp_sign(w_small);
          r_exp      <= fp_exp(w_big);
          r_a_ext    <= ext_sig(w_big);
          r_b_ext    <= w_small_sh;
          r_spec     <= (fp_exp(r_acc) == '1) || (fp_exp(r_opb) == '1);
          r_spec_val <= w_spec_val;
          r_state    <= ADD;
        end
        ADD: begin
          r_sum   <= r_sub ? ({1'b0, r_a_ext} - {1'b0, r_b_ext})
                           : ({1'b0, r_a_ext} + {1'b0, r_b_ext});
          r_state <= NORM;
        end
        NORM: begin
          if (r_last) begin
            r_out_data  <= w_result;
            r_out_count <= w_cnt_inc;
            r_out_valid <= 1'b1;
            r_acc       <= POS_ZERO;
            r_count     <= '0;
          end else begin
            r_acc   <= w_result;
            r_count <= w_cnt_inc;
          end
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fp16_accumulator.sv
//------------------------------------------------------------------------------
// Module   : tb_fp16_accumulator
// Brief    : Directed self-checking bench for fp16_accumulator.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_fp16_accumulator;

  logic CLK = 1'b0;
  logic RESET;
  logic clear;
  logic busy;
  int   n_vec = 0;
  int   n_err = 0;

  fp16_accumulator_if #(.CNT_W(16)) bus ();

  fp16_accumulator #(
    .EXP_W (5),
    .MAN_W (10),
    .CNT_W (16)
  ) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .clear (clear),
    .busy  (busy),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] req);
    n_vec++;
    assert (obs === req) else begin
      n_err++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, req);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic send(input logic [15:0] d, input logic l);
    int w = 0;
    while (!bus.in_ready && w < 20) begin
      tick();
      w++;
    end
    check("send ready", 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = l;
    tick();
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  // Accept cycle k -> out_valid in cycle k+4, i.e. three edges after send returns.
  task automatic expect_result(input string tag, input logic [15:0] ed, input logic [15:0] ec);
    int lat = 0;
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (bus.out_valid) begin
        lat = i;
        break;
      end
    end
    check({tag, " latency"}, 32'(lat), 32'd3);
    check({tag, " data"}, 32'(bus.out_data), 32'(ed));
    check({tag, " count"}, 32'(bus.out_count), 32'(ec));
    tick();
    check({tag, " pulse"}, 32'(bus.out_valid), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] rne_exp;
    RESET        = 1'b1;
    clear        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.in_last  = 1'b0;
    tick();
    tick();
    RESET = 1'b0;
    tick();
    check("rst out_valid", 32'(bus.out_valid), 32'd0);
    check("rst out_data", 32'(bus.out_data), 32'h0);
    check("rst out_count", 32'(bus.out_count), 32'd0);
    check("rst busy", 32'(busy), 32'd0);
    check("rst in_ready", 32'(bus.in_ready), 32'd1);

    // 1.0 + 1.0 = 2.0
    send(16'h3C00, 1'b0);
    check("t1 busy", 32'(busy), 32'd1);
    send(16'h3C00, 1'b1);
    expect_result("t1", 16'h4000, 16'd2);

    // 1.0 + -1.0 = +0
    send(16'h3C00, 1'b0);
    send(16'hBC00, 1'b1);
    expect_result("t2", 16'h0000, 16'd2);

    // max normal doubled overflows; inf + -inf is NaN
    send(16'h7BFF, 1'b0);
    send(16'h7BFF, 1'b1);
    expect_result("t3 ovf", 16'h7C00, 16'd2);
    send(16'h7C00, 1'b0);
    send(16'hFC00, 1'b1);
    expect_result("t3 nan", 16'h7E00, 16'd2);

    // 1.0 + 1.5*2^-11: G and R set, S clear
`ifdef FP16_ACC_RNE_EN
    rne_exp = 16'h3C01;
`else
    rne_exp = 16'h3C00;
`endif
    send(16'h3C00, 1'b0);
    send(16'h1200, 1'b1);
    expect_result("t4 round", rne_exp, 16'd2);

    // 2.0 - 1.0 needs a left normalise; a subnormal operand counts as zero
    send(16'h4000, 1'b0);
    send(16'hBC00, 1'b1);
    expect_result("t7 lzc", 16'h3C00, 16'd2);
    send(16'h3C00, 1'b0);
    send(16'h0001, 1'b1);
    expect_result("t7 subn", 16'h3C00, 16'd2);

    // clear during ADD drops the product and keeps the last result
    send(16'h3C00, 1'b0);
    tick();
    clear = 1'b1;
    check("t5 ready clr", 32'(bus.in_ready), 32'd0);
    tick();
    clear = 1'b0;
    check("t5 busy", 32'(busy), 32'd0);
    check("t5 hold data", 32'(bus.out_data), 32'h3C00);
    check("t5 hold count", 32'(bus.out_count), 32'd2);
    clear        = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = 16'h3C00;
    check("t5 idle clr ready", 32'(bus.in_ready), 32'd0);
    tick();
    check("t5 idle clr busy", 32'(busy), 32'd0);
    check("t5 no valid", 32'(bus.out_valid), 32'd0);
    clear        = 1'b0;
    bus.in_valid = 1'b0;
    send(16'h4000, 1'b1);
    expect_result("t5", 16'h4000, 16'd1);

    // streaming input: one accept every four cycles
    bus.in_valid = 1'b1;
    bus.in_data  = 16'h3C00;
    bus.in_last  = 1'b0;
    for (int i = 0; i < 12; i++) begin
      check("t6 ready", 32'(bus.in_ready), 32'(i % 4 == 0));
      tick();
    end
    bus.in_last = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    tick();
    tick();
    check("t6 busy norm", 32'(busy), 32'd1);
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    check("t6 rst valid", 32'(bus.out_valid), 32'd0);
    check("t6 rst data", 32'(bus.out_data), 32'h0);
    check("t6 rst count", 32'(bus.out_count), 32'd0);
    check("t6 rst busy", 32'(busy), 32'd0);
    tick();
    check("t6 post valid", 32'(bus.out_valid), 32'd0);
    check("t6 post ready", 32'(bus.in_ready), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
